// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared scheduler state type, default frame period and counter width
package gpu_pkg;

    typedef enum logic [2:0] {
        WAIT_BUF,
        LOAD_MAT,
        RENDER,
        DRAIN,
        WAIT_SWAP
    } sched_state_t;

    localparam int DEFAULT_FRAME_PERIOD = 2_000_000;
    localparam int COUNT_W              = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == {COUNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - free-running frame slot timer with registered tick
module frame_timer
    import gpu_pkg::*;
#(
    parameter int FRAME_PERIOD = DEFAULT_FRAME_PERIOD,
    parameter int TIMER_W      = 22
) (
    input  logic clk_in,
    input  logic rst_n_in,
    output logic tick_out
);

    localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(FRAME_PERIOD - 1);
    localparam logic [TIMER_W-1:0] PRE_LAST   = TIMER_W'(FRAME_PERIOD - 2);

    logic [TIMER_W-1:0] timer;

    // Wrap at FRAME_PERIOD-1; tick is computed one count early so the registered
    // tick is high exactly in the cycle where the timer holds its last value.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            timer    <= '0;
            tick_out <= 1'b0;
        end else begin
            timer    <= (timer == LAST_COUNT) ? '0 : timer + 1'b1;
            tick_out <= (timer == PRE_LAST);
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - per-frame GPU sequencer; stats counters built only with FRAME_SCHED_STATS_EN
module frame_scheduler
    import gpu_pkg::*;
#(
    parameter int FRAME_PERIOD = DEFAULT_FRAME_PERIOD,
    parameter int TIMER_W      = 22,
    parameter int IDLE_CYCLES  = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               framebuffer_ready_in,
    input  logic               matrix_valid_in,
    input  logic               fetch_done_in,
    input  logic               pipe_idle_in,
    input  logic               pixel_valid_in,
    output logic               matrix_start_out,
    output logic               fetch_rst_out,
    output logic               fb_switch_out,
    output logic               fb_clear_out,
    output logic [COUNT_W-1:0] pixel_count_out,
    output logic [COUNT_W-1:0] frame_count_out,
    output logic [COUNT_W-1:0] drop_count_out
);

    localparam int                IDLE_W    = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    sched_state_t      state;
    logic [IDLE_W-1:0] idle_cnt;
    logic              tick;

    frame_timer #(
        .FRAME_PERIOD (FRAME_PERIOD),
        .TIMER_W      (TIMER_W)
    ) u_frame_timer (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .tick_out (tick)
    );

    // Frame sequencing: buffer handshake, matrix load, render, drain, then swap on the slot tick.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= WAIT_BUF;
            idle_cnt         <= '0;
            matrix_start_out <= 1'b0;
            fetch_rst_out    <= 1'b1;
            fb_switch_out    <= 1'b0;
            fb_clear_out     <= 1'b0;
        end else begin
            matrix_start_out <= 1'b0;
            fb_switch_out    <= 1'b0;
            fb_clear_out     <= 1'b0;
            case (state)
                WAIT_BUF: begin
                    fetch_rst_out <= 1'b1;
                    if (framebuffer_ready_in) begin
                        matrix_start_out <= 1'b1;
                        state            <= LOAD_MAT;
                    end
                end
                LOAD_MAT: begin
                    if (matrix_valid_in) begin
                        fetch_rst_out <= 1'b0;
                        state         <= RENDER;
                    end else if (!framebuffer_ready_in) begin
                        state <= WAIT_BUF;
                    end
                end
                RENDER: begin
                    // A vanished back buffer wins over a finishing fetch: the frame is abandoned.
                    if (!framebuffer_ready_in) begin
                        fetch_rst_out <= 1'b1;
                        state         <= WAIT_BUF;
                    end else if (fetch_done_in) begin
                        fetch_rst_out <= 1'b1;
                        idle_cnt      <= '0;
                        state         <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pipe_idle_in) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        idle_cnt <= '0;
                        state    <= WAIT_SWAP;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                WAIT_SWAP: begin
                    if (tick) begin
                        fb_switch_out <= 1'b1;
                        fb_clear_out  <= 1'b1;
                        state         <= WAIT_BUF;
                    end
                end
                default: begin
                    fetch_rst_out <= 1'b1;
                    state         <= WAIT_BUF;
                end
            endcase
        end
    end

`ifdef FRAME_SCHED_STATS_EN
    logic [COUNT_W-1:0] pixel_count;
    logic [COUNT_W-1:0] frame_count;
    logic [COUNT_W-1:0] drop_count;

    // Stats: pixels per frame (cleared on entering RENDER), presented frames, missed slots.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pixel_count <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (state == LOAD_MAT && matrix_valid_in) begin
                pixel_count <= '0;
            end else if ((state == RENDER || state == DRAIN) && pixel_valid_in) begin
                pixel_count <= sat_inc(pixel_count);
            end
            if (tick) begin
                if (state == WAIT_SWAP) begin
                    frame_count <= frame_count + 1'b1;
                end else if (state != WAIT_BUF) begin
                    drop_count <= sat_inc(drop_count);
                end
            end
        end
    end

    assign pixel_count_out = pixel_count;
    assign frame_count_out = frame_count;
    assign drop_count_out  = drop_count;
`else
    logic unused_stats;

    assign unused_stats    = pixel_valid_in;
    assign pixel_count_out = '0;
    assign frame_count_out = '0;
    assign drop_count_out  = '0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - randomized and directed bench for frame_scheduler against a frame-level model
`timescale 1ns/1ps
module tb_frame_scheduler;

    localparam int FP   = 100;
    localparam int IDLE = 4;
`ifdef FRAME_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int P_WAIT_BUF  = 0;
    localparam int P_LOAD      = 1;
    localparam int P_RENDER    = 2;
    localparam int P_DRAIN     = 3;
    localparam int P_WAIT_SWAP = 4;

    logic        clk_in               = 1'b0;
    logic        rst_n_in             = 1'b0;
    logic        framebuffer_ready_in = 1'b0;
    logic        matrix_valid_in      = 1'b0;
    logic        fetch_done_in        = 1'b0;
    logic        pipe_idle_in         = 1'b0;
    logic        pixel_valid_in       = 1'b0;
    logic        matrix_start_out;
    logic        fetch_rst_out;
    logic        fb_switch_out;
    logic        fb_clear_out;
    logic [15:0] pixel_count_out;
    logic [15:0] frame_count_out;
    logic [15:0] drop_count_out;

    frame_scheduler #(
        .FRAME_PERIOD (FP),
        .TIMER_W      (7),
        .IDLE_CYCLES  (IDLE)
    ) dut (
        .clk_in               (clk_in),
        .rst_n_in             (rst_n_in),
        .framebuffer_ready_in (framebuffer_ready_in),
        .matrix_valid_in      (matrix_valid_in),
        .fetch_done_in        (fetch_done_in),
        .pipe_idle_in         (pipe_idle_in),
        .pixel_valid_in       (pixel_valid_in),
        .matrix_start_out     (matrix_start_out),
        .fetch_rst_out        (fetch_rst_out),
        .fb_switch_out        (fb_switch_out),
        .fb_clear_out         (fb_clear_out),
        .pixel_count_out      (pixel_count_out),
        .frame_count_out      (frame_count_out),
        .drop_count_out       (drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Frame-level model: phase of the current frame, edges since reset, run of idle cycles.
    int     m_phase;
    longint m_edges;
    int     m_idle_run;
    bit     e_mstart, e_fetch_rst, e_switch;
    int     e_pix, e_frame, e_drop;
    int     switch_count;
    longint last_switch_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, m_edges);
        end
    endtask

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        m_phase     = P_WAIT_BUF;
        m_edges     = 0;
        m_idle_run  = 0;
        e_mstart    = 1'b0;
        e_fetch_rst = 1'b1;
        e_switch    = 1'b0;
        e_pix       = 0;
        e_frame     = 0;
        e_drop      = 0;
        switch_count     = 0;
        last_switch_edge = -1;
    endtask

    // One clock edge of the frame rules; the slot boundary is the last cycle of every FP-cycle period.
    task automatic model_step();
        bit tick;
        int nxt;
        tick     = (m_edges % FP) == FP - 1;
        m_edges++;
        e_mstart = 1'b0;
        e_switch = 1'b0;
        nxt      = m_phase;
        if (tick && m_phase != P_WAIT_BUF && m_phase != P_WAIT_SWAP) e_drop = sat16(e_drop);
        if ((m_phase == P_RENDER || m_phase == P_DRAIN) && pixel_valid_in) e_pix = sat16(e_pix);
        case (m_phase)
            P_WAIT_BUF: if (framebuffer_ready_in) begin e_mstart = 1'b1; nxt = P_LOAD; end
            P_LOAD: begin
                if (matrix_valid_in) begin nxt = P_RENDER; e_fetch_rst = 1'b0; e_pix = 0; end
                else if (!framebuffer_ready_in) nxt = P_WAIT_BUF;
            end
            P_RENDER: begin
                if (!framebuffer_ready_in) begin nxt = P_WAIT_BUF; e_fetch_rst = 1'b1; end
                else if (fetch_done_in) begin nxt = P_DRAIN; e_fetch_rst = 1'b1; m_idle_run = 0; end
            end
            P_DRAIN: begin
                m_idle_run = pipe_idle_in ? m_idle_run + 1 : 0;
                if (m_idle_run == IDLE) nxt = P_WAIT_SWAP;
            end
            default: if (tick) begin e_switch = 1'b1; e_frame = (e_frame + 1) % 65536; nxt = P_WAIT_BUF; end
        endcase
        m_phase = nxt;
    endtask

    // Every-cycle comparison of all outputs against the model while out of reset.
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            check("matrix_start", 32'(matrix_start_out), 32'(e_mstart));
            check("fetch_rst", 32'(fetch_rst_out), 32'(e_fetch_rst));
            check("fb_switch", 32'(fb_switch_out), 32'(e_switch));
            check("fb_clear", 32'(fb_clear_out), 32'(e_switch));
            check("pixel_count", 32'(pixel_count_out), STATS ? 32'(e_pix) : 32'd0);
            check("frame_count", 32'(frame_count_out), STATS ? 32'(e_frame) : 32'd0);
            check("drop_count", 32'(drop_count_out), STATS ? 32'(e_drop) : 32'd0);
            if (fb_switch_out) begin
                switch_count++;
                last_switch_edge = m_edges;
            end
        end
    end

    task automatic step_cycle();
        @(posedge clk_in);
        if (rst_n_in) model_step();
        @(negedge clk_in);
    endtask

    task automatic run_to(input longint edge_no);
        while (m_edges < edge_no) step_cycle();
    endtask

    task automatic clear_inputs();
        framebuffer_ready_in = 1'b0;
        matrix_valid_in      = 1'b0;
        fetch_done_in        = 1'b0;
        pipe_idle_in         = 1'b0;
        pixel_valid_in       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    // Reset, then start (edge 1), matrix valid (edge 3), npix pixels, fetch_done -> DRAIN.
    task automatic to_drain(input int npix);
        do_reset();
        framebuffer_ready_in = 1'b1;
        step_cycle();
        step_cycle();
        matrix_valid_in = 1'b1;
        step_cycle();
        matrix_valid_in = 1'b0;
        pixel_valid_in  = 1'b1;
        repeat (npix) step_cycle();
        pixel_valid_in  = 1'b0;
        fetch_done_in   = 1'b1;
        step_cycle();
        fetch_done_in   = 1'b0;
    endtask

    task automatic idle_pattern(input logic [7:0] pat);
        for (int i = 7; i >= 0; i--) begin
            pipe_idle_in = pat[i];
            step_cycle();
        end
        pipe_idle_in = 1'b0;
    endtask

    task automatic async_reset_check(input string name);
        #2;
        rst_n_in = 1'b0;
        #1;
        check({name, "_mstart"}, 32'(matrix_start_out), 32'd0);
        check({name, "_fetch_rst"}, 32'(fetch_rst_out), 32'd1);
        check({name, "_switch"}, 32'(fb_switch_out), 32'd0);
        check({name, "_clear"}, 32'(fb_clear_out), 32'd0);
        check({name, "_counts"}, 32'(pixel_count_out | frame_count_out | drop_count_out), 32'd0);
        clear_inputs();
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    initial begin
        model_reset();

        // Full frame: 37 pixels, drain by edge 45, swap on the tick at edge 100.
        do_reset();
        framebuffer_ready_in = 1'b1;
        step_cycle();
        check("s1_mstart_c1", 32'(matrix_start_out), 32'd1);
        check("s1_fetch_rst_c1", 32'(fetch_rst_out), 32'd1);
        step_cycle();
        check("s1_mstart_c2", 32'(matrix_start_out), 32'd0);
        check("s1_fetch_rst_c2", 32'(fetch_rst_out), 32'd1);
        matrix_valid_in = 1'b1;
        step_cycle();
        matrix_valid_in = 1'b0;
        check("s1_fetch_rst_fall", 32'(fetch_rst_out), 32'd0);
        pixel_valid_in = 1'b1;
        repeat (37) step_cycle();
        pixel_valid_in = 1'b0;
        fetch_done_in  = 1'b1;
        step_cycle();
        fetch_done_in  = 1'b0;
        check("s1_fetch_rst_drain", 32'(fetch_rst_out), 32'd1);
        pipe_idle_in = 1'b1;
        repeat (4) step_cycle();
        pipe_idle_in = 1'b0;
        run_to(101);
        check("s1_switch_count", 32'(switch_count), 32'd1);
        check("s1_switch_edge", 32'(last_switch_edge), 32'd100);
        check("s1_pixels", 32'(pixel_count_out), STATS ? 32'd37 : 32'd0);
        check("s1_frames", 32'(frame_count_out), STATS ? 32'd1 : 32'd0);

        // Slow frame: busy across the ticks at 100 and 200, swap at 300.
        to_drain(5);
        run_to(250);
        check("s2_no_switch", 32'(switch_count), 32'd0);
        check("s2_drops", 32'(drop_count_out), STATS ? 32'd2 : 32'd0);
        pipe_idle_in = 1'b1;
        repeat (4) step_cycle();
        pipe_idle_in = 1'b0;
        run_to(301);
        check("s2_switch_edge", 32'(last_switch_edge), 32'd300);
        check("s2_switch_count", 32'(switch_count), 32'd1);

        // Broken idle run that recovers with a full run of four.
        to_drain(3);
        idle_pattern(8'b1110_1111);
        run_to(101);
        check("s3a_switch_edge", 32'(last_switch_edge), 32'd100);

        // Broken idle run that never completes: the tick becomes a drop.
        to_drain(3);
        idle_pattern(8'b1110_1110);
        run_to(101);
        check("s3b_no_switch", 32'(switch_count), 32'd0);
        check("s3b_drops", 32'(drop_count_out), STATS ? 32'd1 : 32'd0);

        // Fourth idle cycle lands on the tick: counted as a drop, swap at the next tick.
        to_drain(3);
        run_to(96);
        pipe_idle_in = 1'b1;
        run_to(100);
        pipe_idle_in = 1'b0;
        run_to(201);
        check("s3c_switch_edge", 32'(last_switch_edge), 32'd200);
        check("s3c_switch_count", 32'(switch_count), 32'd1);
        check("s3c_drops", 32'(drop_count_out), STATS ? 32'd1 : 32'd0);

        // Buffer lost mid-render: fetch held in reset again, nothing presented.
        do_reset();
        framebuffer_ready_in = 1'b1;
        run_to(2);
        matrix_valid_in = 1'b1;
        step_cycle();
        matrix_valid_in = 1'b0;
        pixel_valid_in  = 1'b1;
        run_to(5);
        check("s4_fetch_rst_render", 32'(fetch_rst_out), 32'd0);
        framebuffer_ready_in = 1'b0;
        step_cycle();
        pixel_valid_in = 1'b0;
        check("s4_fetch_rst_abort", 32'(fetch_rst_out), 32'd1);
        run_to(150);
        check("s4_no_switch", 32'(switch_count), 32'd0);
        check("s4_frames", 32'(frame_count_out), 32'd0);

        // Asynchronous reset: with a start pulse live, mid-render, and mid-drain.
        do_reset();
        framebuffer_ready_in = 1'b1;
        step_cycle();
        async_reset_check("s5_pulse");
        framebuffer_ready_in = 1'b1;
        run_to(2);
        matrix_valid_in = 1'b1;
        step_cycle();
        matrix_valid_in = 1'b0;
        async_reset_check("s5_render");
        to_drain(20);
        pipe_idle_in = 1'b1;
        step_cycle();
        async_reset_check("s5_drain");
        run_to(120);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            framebuffer_ready_in = ($urandom_range(0, 99) < 97);
            matrix_valid_in      = ($urandom_range(0, 3) == 0);
            fetch_done_in        = ($urandom_range(0, 19) == 0);
            pipe_idle_in         = ($urandom_range(0, 9) < 8);
            pixel_valid_in       = ($urandom_range(0, 1) == 1);
            step_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
